nonce_sweep_controller: RTL and testbench

- Sequences one mining job across the SHA pipeline.
- Issues nonces from a programmed range with a ready/valid handshake and tracks in-flight hashes.
- Consumes per-result pass/fail from the hash validator, latches the first winning nonce, drains the pipeline, and reports completion.
- Owns the difficulty value driven to the validator for the whole job.

---
 rtl/nonce_sweep_controller.sv | 204 ++++++++++++++++++++
 tb/tb_nonce_sweep_controller.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sweep_controller.sv
// Sweeps one mining job's nonce range into the SHA pipeline, tracks hashes in flight,
// latches the first winning nonce, drains and reports. Optional hit counter: NONCE_SWEEP_HIT_COUNT_EN.
module nonce_sweep_controller #(
    parameter int NONCE_W         = 32,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               job_start,
    input  logic [9:0]         job_difficulty,
    input  logic [NONCE_W-1:0] job_nonce_first,
    input  logic [NONCE_W-1:0] job_nonce_last,
    input  logic               abort,
    output logic [9:0]         difficulty,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [NONCE_W-1:0] issue_nonce,
    input  logic               result_valid,
    input  logic [NONCE_W-1:0] result_nonce,
    input  logic               result_hit,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               exhausted,
    output logic               aborted,
    output logic               err_spurious
`ifdef NONCE_SWEEP_HIT_COUNT_EN
    ,
    output logic [15:0]        hit_count
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [9:0]         r_difficulty;
    logic [NONCE_W-1:0] r_cur;
    logic [NONCE_W-1:0] r_last;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   w_out_nxt;
    logic               r_found;
    logic [NONCE_W-1:0] r_found_nonce;
    logic               r_exhausted;
    logic               r_aborted;
    logic               r_err_spurious;

    logic w_issue_valid;
    logic w_hs;
    logic w_res;
    logic w_hit_first;
    logic w_spur;
    logic w_accept;
    logic w_set_abort;
    logic w_set_exh;

    assign w_issue_valid = (r_state == S_RUN) && (r_outstanding < MAX_CNT);
    assign w_hs          = w_issue_valid & issue_ready;
    // Results are ignored in IDLE so stragglers from a reset-killed job stay harmless.
    assign w_res         = result_valid && (r_state != S_IDLE);
    assign w_hit_first   = w_res && result_hit && !r_found;
    assign w_spur        = w_res && (r_outstanding == '0) && !w_hs;

    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_hs && !w_res) begin
            w_out_nxt = r_outstanding + CNT_W'(1);
        end else if (w_res && !w_hs && (r_outstanding != '0)) begin
            w_out_nxt = r_outstanding - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_set_abort = 1'b0;
        w_set_exh   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (job_start) begin
                    w_accept = 1'b1;
                    if (job_nonce_last < job_nonce_first) begin
                        w_state_nxt = S_DONE;
                        w_set_exh   = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_hit_first) begin
                    w_state_nxt = S_DRAIN;
                end else if (abort) begin
                    w_state_nxt = S_DRAIN;
                    w_set_abort = 1'b1;
                end else if (w_hs && (r_cur == r_last)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort && !r_found && !w_hit_first) begin
                    w_set_abort = 1'b1;
                end
                if (w_out_nxt == '0) begin
                    w_state_nxt = S_DONE;
                    w_set_exh   = !r_found && !w_hit_first && !r_aborted && !w_set_abort;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_difficulty   <= '0;
            r_cur          <= '0;
            r_last         <= '0;
            r_outstanding  <= '0;
            r_found        <= 1'b0;
            r_found_nonce  <= '0;
            r_exhausted    <= 1'b0;
            r_aborted      <= 1'b0;
            r_err_spurious <= 1'b0;
        end else if (w_accept) begin
            r_difficulty   <= job_difficulty;
            r_cur          <= job_nonce_first;
            r_last         <= job_nonce_last;
            r_outstanding  <= '0;
            r_found        <= 1'b0;
            r_found_nonce  <= '0;
            r_exhausted    <= w_set_exh;
            r_aborted      <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            r_outstanding <= w_out_nxt;
            // Holding at last keeps an all-ones range end from wrapping to nonce 0.
            if (w_hs && (r_cur != r_last)) begin
                r_cur <= r_cur + NONCE_W'(1);
            end
            if (w_hit_first) begin
                r_found       <= 1'b1;
                r_found_nonce <= result_nonce;
            end
            if (w_set_abort) begin
                r_aborted <= 1'b1;
            end
            if (w_set_exh) begin
                r_exhausted <= 1'b1;
            end
            if (w_spur) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

`ifdef NONCE_SWEEP_HIT_COUNT_EN
    logic [15:0] r_hit_count;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hit_count <= '0;
        end else if (w_accept) begin
            r_hit_count <= '0;
        end else if (w_res && result_hit) begin
            r_hit_count <= sat_inc16(r_hit_count);
        end
    end

    assign hit_count = r_hit_count;
`endif

    assign difficulty   = r_difficulty;
    assign issue_valid  = w_issue_valid;
    assign issue_nonce  = r_cur;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign found        = r_found;
    assign found_nonce  = r_found_nonce;
    assign exhausted    = r_exhausted;
    assign aborted      = r_aborted;
    assign err_spurious = r_err_spurious;

endmodule

// File: tb/tb_nonce_sweep_controller.sv
// Directed bench for nonce_sweep_controller with a 3-cycle result pipeline model.
module tb_nonce_sweep_controller;

    localparam int NW   = 32;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          job_start = 1'b0;
    logic [9:0]    job_difficulty = '0;
    logic [NW-1:0] job_nonce_first = '0;
    logic [NW-1:0] job_nonce_last = '0;
    logic          abort = 1'b0;
    logic [9:0]    difficulty;
    logic          issue_valid;
    logic          issue_ready = 1'b0;
    logic [NW-1:0] issue_nonce;
    logic          result_valid = 1'b0;
    logic [NW-1:0] result_nonce = '0;
    logic          result_hit = 1'b0;
    logic          busy;
    logic          done;
    logic          found;
    logic [NW-1:0] found_nonce;
    logic          exhausted;
    logic          aborted;
    logic          err_spurious;
`ifdef NONCE_SWEEP_HIT_COUNT_EN
    logic [15:0]   hit_count;
`endif

    always #5 clk = ~clk;

    nonce_sweep_controller #(
        .NONCE_W(NW),
        .MAX_OUTSTANDING(MAXO)
    ) u_dut (
        .clk(clk),
        .reset_n(reset_n),
        .job_start(job_start),
        .job_difficulty(job_difficulty),
        .job_nonce_first(job_nonce_first),
        .job_nonce_last(job_nonce_last),
        .abort(abort),
        .difficulty(difficulty),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_nonce(issue_nonce),
        .result_valid(result_valid),
        .result_nonce(result_nonce),
        .result_hit(result_hit),
        .busy(busy),
        .done(done),
        .found(found),
        .found_nonce(found_nonce),
        .exhausted(exhausted),
        .aborted(aborted),
        .err_spurious(err_spurious)
`ifdef NONCE_SWEEP_HIT_COUNT_EN
        ,
        .hit_count(hit_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Pipeline model and observation counters
    logic          auto_ret = 1'b0;
    logic          hit_en = 1'b0;
    logic [NW-1:0] hit_a = '0;
    logic [NW-1:0] hit_b = '0;
    logic          pipe_v [2];
    logic [NW-1:0] pipe_n [2];
    int            n_hs = 0;
    int            done_cnt = 0;
    logic [NW-1:0] last_iss = '0;
    logic          saw_zero = 1'b0;
    logic          saw_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic          hs;
        logic [NW-1:0] nonce_now;
        hs = issue_valid & issue_ready;
        nonce_now = issue_nonce;
        if (hs) begin
            n_hs++;
            last_iss = nonce_now;
            if (nonce_now == '0) saw_zero = 1'b1;
        end
        if (issue_valid) saw_valid = 1'b1;
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        job_start = 1'b0;
        abort = 1'b0;
        if (auto_ret) begin
            result_valid = pipe_v[1];
            result_nonce = pipe_n[1];
            result_hit   = pipe_v[1] && hit_en && (pipe_n[1] == hit_a || pipe_n[1] == hit_b);
            pipe_v[1] = pipe_v[0];
            pipe_n[1] = pipe_n[0];
            pipe_v[0] = hs;
            pipe_n[0] = nonce_now;
        end else begin
            result_valid = 1'b0;
            result_hit   = 1'b0;
        end
    endtask

    task automatic start_job(input logic [NW-1:0] first, input logic [NW-1:0] last,
                             input logic [9:0] diff);
        job_nonce_first = first;
        job_nonce_last  = last;
        job_difficulty  = diff;
        job_start       = 1'b1;
        n_hs      = 0;
        done_cnt  = 0;
        saw_zero  = 1'b0;
        saw_valid = 1'b0;
        last_iss  = '0;
        for (int i = 0; i < 2; i++) pipe_v[i] = 1'b0;
        step();
    endtask

    task automatic wait_done(input int max_cyc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic check_cleared(input string pfx);
        check({pfx, "_difficulty"}, 32'(difficulty), 32'h0);
        check({pfx, "_issue_valid"}, 32'(issue_valid), 32'h0);
        check({pfx, "_issue_nonce"}, issue_nonce, 32'h0);
        check({pfx, "_busy"}, 32'(busy), 32'h0);
        check({pfx, "_done"}, 32'(done), 32'h0);
        check({pfx, "_found"}, 32'(found), 32'h0);
        check({pfx, "_found_nonce"}, found_nonce, 32'h0);
        check({pfx, "_exhausted"}, 32'(exhausted), 32'h0);
        check({pfx, "_aborted"}, 32'(aborted), 32'h0);
        check({pfx, "_err_spurious"}, 32'(err_spurious), 32'h0);
`ifdef NONCE_SWEEP_HIT_COUNT_EN
        check({pfx, "_hit_count"}, 32'(hit_count), 32'h0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          ok;
        logic          stable;
        logic [NW-1:0] held;
        pipe_v[0] = 1'b0;
        pipe_v[1] = 1'b0;
        pipe_n[0] = '0;
        pipe_n[1] = '0;

        step();
        step();
        check_cleared("rst");
        reset_n = 1'b1;
        step();

        // No-hit sweep of 0x10..0x13
        issue_ready = 1'b1;
        auto_ret    = 1'b1;
        hit_en      = 1'b0;
        start_job(32'h10, 32'h13, 10'h3);
        check("t1_difficulty", 32'(difficulty), 32'h3);
        check("t1_busy", 32'(busy), 32'h1);
        wait_done(40, ok);
        check("t1_done_seen", 32'(ok), 32'h1);
        check("t1_handshakes", 32'(n_hs), 32'd4);
        check("t1_last_nonce", last_iss, 32'h13);
        check("t1_exhausted", 32'(exhausted), 32'h1);
        check("t1_found", 32'(found), 32'h0);
        check("t1_aborted", 32'(aborted), 32'h0);
        step();
        check("t1_done_once", 32'(done_cnt), 32'd1);
        check("t1_idle", 32'(busy), 32'h0);

        // Hits on 7 and 9 in range 0..99
        hit_en = 1'b1;
        hit_a  = 32'd7;
        hit_b  = 32'd9;
        start_job(32'd0, 32'd99, 10'h5);
        wait_done(60, ok);
        check("t2_done_seen", 32'(ok), 32'h1);
        check("t2_found", 32'(found), 32'h1);
        check("t2_found_nonce", found_nonce, 32'd7);
        check("t2_exhausted", 32'(exhausted), 32'h0);
        check("t2_handshakes", 32'(n_hs), 32'd11);
        check("t2_last_nonce", last_iss, 32'd10);
`ifdef NONCE_SWEEP_HIT_COUNT_EN
        check("t2_hit_count", 32'(hit_count), 32'd2);
`endif
        step();
        hit_en = 1'b0;

        // Outstanding limit, backpressure, then abort with 3 in flight
        auto_ret = 1'b0;
        start_job(32'h100, 32'h1FF, 10'h7);
        for (int i = 0; i < 6; i++) step();
        check("t3_hs_at_limit", 32'(n_hs), 32'd4);
        check("t3_valid_at_limit", 32'(issue_valid), 32'h0);
        result_valid = 1'b1;
        result_nonce = 32'h100;
        step();
        for (int i = 0; i < 3; i++) step();
        check("t3_one_more_hs", 32'(n_hs), 32'd5);
        check("t3_valid_relimit", 32'(issue_valid), 32'h0);
        issue_ready  = 1'b0;
        result_valid = 1'b1;
        result_nonce = 32'h101;
        step();
        held   = issue_nonce;
        stable = issue_valid;
        for (int i = 0; i < 5; i++) begin
            step();
            if (issue_nonce !== held || issue_valid !== 1'b1) stable = 1'b0;
        end
        check("t3_nonce_held", held, 32'h105);
        check("t3_stable", 32'(stable), 32'h1);
        check("t3_no_hs_stalled", 32'(n_hs), 32'd5);
        abort = 1'b1;
        step();
        check("t3_abort_drain_valid", 32'(issue_valid), 32'h0);
        check("t3_aborted_flag", 32'(aborted), 32'h1);
        for (int i = 0; i < 2; i++) begin
            result_valid = 1'b1;
            result_nonce = 32'h102 + 32'(i);
            step();
        end
        check("t3_not_done_early", 32'(done), 32'h0);
        check("t3_busy_draining", 32'(busy), 32'h1);
        result_valid = 1'b1;
        result_nonce = 32'h104;
        step();
        check("t3_done", 32'(done), 32'h1);
        check("t3_aborted", 32'(aborted), 32'h1);
        check("t3_exhausted", 32'(exhausted), 32'h0);
        check("t3_found", 32'(found), 32'h0);
        step();
        check("t3_idle", 32'(busy), 32'h0);

        // Top-of-range wrap and inverted range
        issue_ready = 1'b1;
        auto_ret    = 1'b1;
        start_job(32'hFFFF_FFFE, 32'hFFFF_FFFF, 10'h1);
        wait_done(30, ok);
        check("t4_done_seen", 32'(ok), 32'h1);
        check("t4_handshakes", 32'(n_hs), 32'd2);
        check("t4_no_zero", 32'(saw_zero), 32'h0);
        check("t4_exhausted", 32'(exhausted), 32'h1);
        step();
        start_job(32'd5, 32'd4, 10'h1);
        wait_done(2, ok);
        check("t4i_done_seen", 32'(ok), 32'h1);
        check("t4i_exhausted", 32'(exhausted), 32'h1);
        check("t4i_no_valid", 32'(saw_valid), 32'h0);
        check("t4i_handshakes", 32'(n_hs), 32'd0);
        step();

        // job_start while busy, then reset mid-RUN
        start_job(32'd0, 32'd50, 10'h2A);
        job_start      = 1'b1;
        job_difficulty = 10'h155;
        step();
        check("t5_diff_held", 32'(difficulty), 32'h2A);
        check("t5_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        step();
        check_cleared("t5_rst");
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t5_no_spur_idle", 32'(err_spurious), 32'h0);

        // Spurious result with nothing outstanding
        issue_ready = 1'b0;
        auto_ret    = 1'b0;
        start_job(32'd0, 32'd3, 10'h4);
        result_valid = 1'b1;
        result_nonce = 32'h55;
        step();
        check("t6_spurious", 32'(err_spurious), 32'h1);
        issue_ready = 1'b1;
        auto_ret    = 1'b1;
        wait_done(40, ok);
        check("t6_done_seen", 32'(ok), 32'h1);
        check("t6_spur_held", 32'(err_spurious), 32'h1);
        check("t6_exhausted", 32'(exhausted), 32'h1);
        step();
        start_job(32'd0, 32'd1, 10'h4);
        check("t6_spur_cleared", 32'(err_spurious), 32'h0);
        wait_done(30, ok);
        check("t6b_done_seen", 32'(ok), 32'h1);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
